fitness_evaluator: RTL and testbench
====================================

FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, number of clocks each input vector is held before the candidate outputs are sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request an evaluation run; honoured only in IDLE.
REQ-005 target  input  64  expected truth table; bit 4*v+o is the expected value of candidate output o for input vector v (v = 0..15).
REQ-006 dut_in  output  4  vector driven to the candidate; bit i drives candidate input i.
REQ-007 dut_out  input  4  candidate outputs; bit o is candidate output o.
REQ-008 busy  output  1  high while a run is in progress (SETTLE or SAMPLE).
REQ-009 done  output  1  one-cycle pulse when the run results are final.
REQ-010 score  output  7  count of matching output bits over the run, 0..64.
REQ-011 perfect  output  1  high when score equals 64.
REQ-012 mismatch_vec  output  16  bit v set if any output bit was wrong at vector v.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE with start=1, the block SHALL perform all of the following on the next edge:
- latch target into an internal register;
- set vec=0;
- clear score and mismatch_vec;
- load the settle counter with SETTLE_CYCLES;
- enter SETTLE.
REQ-015 dut_in SHALL always equal the registered vec.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and compare dut_out with latched target[4*vec+3:4*vec].
- score is incremented by the number of equal bits (0..4).
- mismatch_vec[vec] is set if any bit differs.
REQ-018 From SAMPLE, the FSM SHALL go to DONE if vec==15; otherwise it SHALL increment vec, reload the settle counter and return to SETTLE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: with the start edge as cycle 0, vector k SHALL be sampled in cycle (k+1)*(SETTLE_CYCLES+1), and done SHALL be high in cycle 16*(SETTLE_CYCLES+1)+1; for the default, this is cycle 81.
REQ-021 score, perfect and mismatch_vec SHALL be final in the DONE cycle and held until the next accepted start.
REQ-022 perfect SHALL be registered; it updates with score and is never asserted mid-run.
REQ-023 busy SHALL be 1 in SETTLE and SAMPLE only.
REQ-024 start SHALL be ignored in SETTLE, SAMPLE and DONE; it is not queued.
REQ-025 Changes on target after start is accepted SHALL NOT affect the run in progress.
REQ-026 score arithmetic SHALL be 7-bit unsigned; the maximum value of 64 cannot overflow.
REQ-027 vec SHALL NOT wrap within a run; after DONE, vec holds 15 until the next start.

Reset
REQ-028 While reset=1, the following SHALL hold immediately, independent of clk:
- state=IDLE;
- vec=0, so dut_in=0;
- busy=0, done=0;
- score=0, perfect=0, mismatch_vec=0;
- settle counter=0, latched target=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse and all partial results discarded.
REQ-030 The first start after reset deassertion SHALL be accepted on the first edge at which reset is low.

Verification
REQ-031 Identity candidate (dut_out=dut_in, combinational), target[4v+3:4v]=v for all v, SETTLE_CYCLES=4, start at cycle 0 -> done only at cycle 81, score=64, perfect=1, mismatch_vec=0x0000.
REQ-032 dut_out stuck at 4'b0000, target=all ones -> score=0, perfect=0, mismatch_vec=0xFFFF.
REQ-033 Identity candidate, target identity except vector 5 expected 4'b1111 -> score=62, perfect=0, mismatch_vec=0x0020.
REQ-034 Start pulsed again at cycle 40 and target flipped to all zeros at cycle 40 during the REQ-031 run -> results unchanged and exactly one done pulse at cycle 81.
REQ-035 Reset asserted at cycle 30 of a run -> all outputs at reset values in the same cycle, no done pulse; a new start after release gives the full REQ-031 result.
REQ-036 Identity candidate with a 3-cycle output delay -> SETTLE_CYCLES=4 gives score=64; SETTLE_CYCLES=2 gives score<64 with the mismatch_vec bits set for vectors whose value differs from the previous vector.

Source files
------------

// File: rtl/fitness_evaluator.sv
// rtl/fitness_evaluator.sv - truth-table fitness scorer for a 4-input/4-output candidate circuit
// Walks all 16 input vectors, waits for the candidate to settle, then scores each vector against the target.
module fitness_evaluator #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] target,
   output logic [3:0]  dut_in,
   input  logic [3:0]  dut_out,
   output logic        busy,
   output logic        done,
   output logic [6:0]  score,
   output logic        perfect,
   output logic [15:0] mismatch_vec
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   state_t      state, state_nx;
   logic [3:0]  vec;
   logic [7:0]  settle_cnt;
   logic [63:0] tgt_q;
   logic [3:0]  expect_nib;
   logic [3:0]  eq_bits;
   logic [6:0]  eq_count;
   logic [6:0]  score_nx;

   assign dut_in     = vec;
   assign expect_nib = tgt_q[{vec, 2'b00} +: 4];
   assign eq_bits    = ~(dut_out ^ expect_nib);
   assign eq_count   = {6'd0, eq_bits[0]} + {6'd0, eq_bits[1]}
                     + {6'd0, eq_bits[2]} + {6'd0, eq_bits[3]};
   assign score_nx   = score + eq_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_cnt <= 8'd1) begin
               state_nx = SAMPLE;
            end
         end
         SAMPLE: begin
            busy     = 1'b1;
            state_nx = (vec == 4'd15) ? DONE : SETTLE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Results are only touched on an accepted start or in SAMPLE, so they hold after DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec          <= 4'd0;
         settle_cnt   <= 8'd0;
         tgt_q        <= 64'd0;
         score        <= 7'd0;
         perfect      <= 1'b0;
         mismatch_vec <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tgt_q        <= target;
                  vec          <= 4'd0;
                  score        <= 7'd0;
                  perfect      <= 1'b0;
                  mismatch_vec <= 16'd0;
                  settle_cnt   <= SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (settle_cnt != 8'd0) begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            SAMPLE: begin
               score   <= score_nx;
               perfect <= (score_nx == 7'd64);
               if (eq_bits != 4'hF) begin
                  mismatch_vec[vec] <= 1'b1;
               end
               if (vec != 4'd15) begin
                  vec        <= vec + 4'd1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fitness_evaluator.sv
// tb/tb_fitness_evaluator.sv - scoreboard bench for fitness_evaluator
// Two instances (settle 4 and settle 2) share clock, reset and target; each has its own candidate model.
module tb_fitness_evaluator;

   typedef struct {
      logic [6:0]  score;
      logic        perfect;
      logic [15:0] mvec;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic [63:0] target;
   logic [1:0]  mode;
   logic [3:0]  dut_in_a, dut_out_a, dut_in_b, dut_out_b;
   logic [3:0]  da1, da2, da3, db1, db2, db3;
   logic        busy_a, done_a, perfect_a, busy_b, done_b, perfect_b;
   logic [6:0]  score_a, score_b;
   logic [15:0] mvec_a, mvec_b;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   sc_a  = 0;
   int   sc_b  = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [63:0] t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fitness_evaluator #(.SETTLE_CYCLES(4)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .target(target),
      .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
      .score(score_a), .perfect(perfect_a), .mismatch_vec(mvec_a)
   );

   fitness_evaluator #(.SETTLE_CYCLES(2)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .target(target),
      .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
      .score(score_b), .perfect(perfect_b), .mismatch_vec(mvec_b)
   );

   // Candidate: mode 0 identity, 1 stuck at zero, 2 identity delayed three clocks.
   always @(posedge clk) begin
      da1 <= dut_in_a; da2 <= da1; da3 <= da2;
      db1 <= dut_in_b; db2 <= db1; db3 <= db2;
   end

   always_comb begin
      case (mode)
         2'd0:    begin dut_out_a = dut_in_a; dut_out_b = dut_in_b; end
         2'd1:    begin dut_out_a = 4'd0;     dut_out_b = 4'd0;     end
         default: begin dut_out_a = da3;      dut_out_b = db3;      end
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [6:0] s, input logic p, input logic [15:0] m, input int l);
      exp_t e;
      e.score = s; e.perfect = p; e.mvec = m; e.lat = l;
      return e;
   endfunction

   function automatic logic [63:0] id_tgt();
      logic [63:0] r;
      for (int v = 0; v < 16; v++) r[4*v +: 4] = 4'(v);
      return r;
   endfunction

   always @(negedge clk) begin
      if (done_a) begin
         if (qa.size() == 0) begin
            chk("done_a_unexpected", {31'd0, done_a}, 32'd0);
         end else begin
            ea = qa.pop_front();
            chk("score_a", {25'd0, score_a}, {25'd0, ea.score});
            chk("perfect_a", {31'd0, perfect_a}, {31'd0, ea.perfect});
            chk("mvec_a", {16'd0, mvec_a}, {16'd0, ea.mvec});
            chk("latency_a", cyc - sc_a + 1, ea.lat);
            chk("busy_in_done_a", {31'd0, busy_a}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (done_b) begin
         if (qb.size() == 0) begin
            chk("done_b_unexpected", {31'd0, done_b}, 32'd0);
         end else begin
            eb = qb.pop_front();
            chk("score_b", {25'd0, score_b}, {25'd0, eb.score});
            chk("perfect_b", {31'd0, perfect_b}, {31'd0, eb.perfect});
            chk("mvec_b", {16'd0, mvec_b}, {16'd0, eb.mvec});
            chk("latency_b", cyc - sc_b + 1, eb.lat);
         end
      end
   end

   task automatic launch_a(input logic [63:0] tg, input exp_t e);
      target  = tg;
      start_a = 1'b1;
      qa.push_back(e);
      @(posedge clk); #1;
      sc_a    = cyc;
      start_a = 1'b0;
   endtask

   task automatic launch_b(input logic [63:0] tg, input exp_t e);
      target  = tg;
      start_b = 1'b1;
      qb.push_back(e);
      @(posedge clk); #1;
      sc_b    = cyc;
      start_b = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", qa.size() + qb.size(), 32'd0);
      qa.delete();
      qb.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_dut_in"}, {28'd0, dut_in_a}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
      chk({tag, "_score"}, {25'd0, score_a}, 32'd0);
      chk({tag, "_perfect"}, {31'd0, perfect_a}, 32'd0);
      chk({tag, "_mvec"}, {16'd0, mvec_a}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; target = 64'd0; mode = 2'd0;
      @(posedge clk); #1;
      chk_reset_a("rst");
      reset = 1'b0;

      mode = 2'd0;
      launch_a(id_tgt(), mk(7'd64, 1'b1, 16'h0000, 81));
      wait_drain();
      chk("hold_score", {25'd0, score_a}, 32'd64);
      chk("hold_perfect", {31'd0, perfect_a}, 32'd1);
      chk("hold_vec", {28'd0, dut_in_a}, 32'd15);

      mode = 2'd1;
      launch_a(64'hFFFF_FFFF_FFFF_FFFF, mk(7'd0, 1'b0, 16'hFFFF, 81));
      wait_drain();

      mode = 2'd0;
      t = id_tgt();
      t[23:20] = 4'hF;
      launch_a(t, mk(7'd62, 1'b0, 16'h0020, 81));
      wait_drain();

      // Restart and target change mid-run must not disturb the run.
      launch_a(id_tgt(), mk(7'd64, 1'b1, 16'h0000, 81));
      repeat (39) @(posedge clk);
      #1;
      chk("midrun_busy", {31'd0, busy_a}, 32'd1);
      chk("midrun_perfect", {31'd0, perfect_a}, 32'd0);
      start_a = 1'b1;
      target  = 64'd0;
      @(posedge clk); #1;
      start_a = 1'b0;
      wait_drain();

      launch_a(id_tgt(), mk(7'd64, 1'b1, 16'h0000, 81));
      repeat (29) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      qa.delete();
      chk_reset_a("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      launch_a(id_tgt(), mk(7'd64, 1'b1, 16'h0000, 81));
      wait_drain();

      mode = 2'd2;
      launch_a(id_tgt(), mk(7'd64, 1'b1, 16'h0000, 81));
      wait_drain();

      // Settle of 2 against a 3-clock candidate sees the previous vector for every k>0.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      launch_b(id_tgt(), mk(7'd38, 1'b0, 16'hFFFE, 49));
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
